// File: rtl/mem_stage.sv
// Memory-access stage: waits for data-SRAM responses, extends load data, forwards results to DS
// and passes exception/CSR fields to WB.
module mem_stage #(
    parameter int ES_TO_MS_BUS_WD = 173,
    parameter int MS_TO_WS_BUS_WD = 168,
    parameter int MS_FORWARD_WD   = 40
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       es_to_ms_valid,
    input  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
    output logic                       ms_allowin,
    input  logic                       ws_allowin,
    output logic                       ms_to_ws_valid,
    output logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus,
    input  logic                       data_sram_data_ok,
    input  logic [31:0]                data_sram_rdata,
    input  logic                       flush,
    output logic [MS_FORWARD_WD-1:0]   ms_forward,
    output logic                       ms_ex
);

    logic                       ms_valid_q, ms_valid_d;
    logic [ES_TO_MS_BUS_WD-1:0] ms_bus_q;
    logic                       buf_valid_q, buf_valid_d;
    logic [31:0]                buf_data_q, buf_data_d;
    logic                       cancel_q, cancel_d;

    logic        ms_ertn;
    logic [4:0]  ms_dest;
    logic        ms_gr_we;
    logic        ms_res_from_csr;
    logic [31:0] ms_alu_result;
    logic        ms_excp;
    logic        ms_mem_req;
    logic        ms_res_from_mem;
    logic [2:0]  ms_load_op;

    assign ms_ertn         = ms_bus_q[32];
    assign ms_dest         = ms_bus_q[37:33];
    assign ms_gr_we        = ms_bus_q[38];
    assign ms_res_from_csr = ms_bus_q[39];
    assign ms_alu_result   = ms_bus_q[71:40];
    assign ms_excp         = ms_bus_q[72];
    assign ms_mem_req      = ms_bus_q[168];
    assign ms_res_from_mem = ms_bus_q[169];
    assign ms_load_op      = ms_bus_q[172:170];

    logic wait_data;
    logic data_ok_live;
    logic ms_ready_go;
    logic ms_to_ws_fire;

    assign wait_data    = ms_valid_q & ms_mem_req & ~ms_excp;
    // A response arriving while cancel is set belongs to a flushed instruction.
    assign data_ok_live = data_sram_data_ok & ~cancel_q;
    assign ms_ready_go  = ~wait_data | data_ok_live | buf_valid_q;
    assign ms_allowin   = ~ms_valid_q | (ms_ready_go & ws_allowin);
    assign ms_to_ws_valid = ms_valid_q & ms_ready_go & ~flush;
    assign ms_to_ws_fire  = ms_valid_q & ms_ready_go & ws_allowin;

    always_comb begin
        ms_valid_d  = ms_valid_q;
        buf_valid_d = buf_valid_q;
        buf_data_d  = buf_data_q;
        cancel_d    = cancel_q;

        if (flush) begin
            ms_valid_d = 1'b0;
        end else if (ms_allowin) begin
            ms_valid_d = es_to_ms_valid;
        end

        if (flush || ms_to_ws_fire) begin
            buf_valid_d = 1'b0;
        end else if (data_ok_live && wait_data && !buf_valid_q && !ws_allowin) begin
            buf_valid_d = 1'b1;
            buf_data_d  = data_sram_rdata;
        end

        // Set only while the flushed load's own response is still outstanding.
        if (flush && wait_data && !buf_valid_q && !data_ok_live) begin
            cancel_d = 1'b1;
        end else if (data_sram_data_ok) begin
            cancel_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ms_valid_q  <= 1'b0;
            buf_valid_q <= 1'b0;
            buf_data_q  <= 32'd0;
            cancel_q    <= 1'b0;
        end else begin
            ms_valid_q  <= ms_valid_d;
            buf_valid_q <= buf_valid_d;
            buf_data_q  <= buf_data_d;
            cancel_q    <= cancel_d;
        end
    end

    always_ff @(posedge clk) begin
        if (es_to_ms_valid && ms_allowin) begin
            ms_bus_q <= es_to_ms_bus;
        end
    end

    logic [31:0] load_src;
    logic [7:0]  byte_lane [4];
    logic [7:0]  sel_byte;
    logic [15:0] sel_half;
    logic [31:0] load_result;
    logic [31:0] ms_result;

    assign load_src = buf_valid_q ? buf_data_q : data_sram_rdata;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign byte_lane[gi] = load_src[gi*8 +: 8];
        end
    endgenerate

    assign sel_byte = byte_lane[ms_alu_result[1:0]];
    assign sel_half = ms_alu_result[1] ? load_src[31:16] : load_src[15:0];

    always_comb begin
        load_result = load_src;
        case (ms_load_op)
            3'b001:  load_result = {{24{sel_byte[7]}}, sel_byte};
            3'b010:  load_result = {24'd0, sel_byte};
            3'b011:  load_result = {{16{sel_half[15]}}, sel_half};
            3'b100:  load_result = {16'd0, sel_half};
            default: load_result = load_src;
        endcase
    end

    // Excepting loads keep the address so WB can report it as the bad virtual address.
    assign ms_result = (ms_res_from_mem && !ms_excp) ? load_result : ms_alu_result;

    assign ms_to_ws_bus = {ms_bus_q[167:72], ms_result, ms_bus_q[39:0]};

    logic blocking;
    assign blocking   = ms_valid_q & (ms_res_from_csr | (ms_res_from_mem & ~ms_ready_go));
    assign ms_forward = {blocking, ms_result, ms_dest, ms_gr_we, ms_valid_q};
    assign ms_ex      = ms_valid_q & (ms_excp | ms_ertn);

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: load extension, buffering under backpressure, flush cancel,
// exceptions, back-to-back issue and reset during a wait.
module tb_mem_stage;

    logic         clk = 1'b0;
    logic         reset;
    logic         es_to_ms_valid;
    logic [172:0] es_to_ms_bus;
    logic         ms_allowin;
    logic         ws_allowin;
    logic         ms_to_ws_valid;
    logic [167:0] ms_to_ws_bus;
    logic         data_sram_data_ok;
    logic [31:0]  data_sram_rdata;
    logic         flush;
    logic [39:0]  ms_forward;
    logic         ms_ex;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mem_stage dut (
        .clk               (clk),
        .reset             (reset),
        .es_to_ms_valid    (es_to_ms_valid),
        .es_to_ms_bus      (es_to_ms_bus),
        .ms_allowin        (ms_allowin),
        .ws_allowin        (ws_allowin),
        .ms_to_ws_valid    (ms_to_ws_valid),
        .ms_to_ws_bus      (ms_to_ws_bus),
        .data_sram_data_ok (data_sram_data_ok),
        .data_sram_rdata   (data_sram_rdata),
        .flush             (flush),
        .ms_forward        (ms_forward),
        .ms_ex             (ms_ex)
    );

    function automatic logic [172:0] mk_bus(input logic [31:0] pc, input logic [4:0] dest,
                                            input logic [31:0] alu, input logic excp,
                                            input logic [15:0] excp_num, input logic mem_req,
                                            input logic res_from_mem, input logic [2:0] load_op,
                                            input logic ertn);
        logic [172:0] b;
        b = '0;
        b[31:0]    = pc;
        b[32]      = ertn;
        b[37:33]   = dest;
        b[38]      = 1'b1;
        b[39]      = 1'b0;
        b[71:40]   = alu;
        b[72]      = excp;
        b[88:73]   = excp_num;
        b[89]      = 1'b1;
        b[103:90]  = 14'h0123;
        b[135:104] = 32'hFFFF0000;
        b[167:136] = 32'hA5A5A5A5;
        b[168]     = mem_req;
        b[169]     = res_from_mem;
        b[172:170] = load_op;
        return b;
    endfunction

    function automatic logic [167:0] exp_out(input logic [172:0] b, input logic [31:0] res);
        return {b[167:72], res, b[39:0]};
    endfunction

    task automatic chk(input string tag, input logic [167:0] obs, input logic [167:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
        $display("check %-14s observed=%h", tag, obs);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    logic [172:0] b1, b2, b3a, b3b, b4, b5a, b5b, b6;

    initial begin
        reset = 1'b1;
        es_to_ms_valid = 1'b0;
        es_to_ms_bus = '0;
        ws_allowin = 1'b1;
        data_sram_data_ok = 1'b0;
        data_sram_rdata = 32'd0;
        flush = 1'b0;
        cyc();
        cyc();
        reset = 1'b0;
        settle();
        chk("rst_valid", 168'(ms_to_ws_valid), 168'd0);
        chk("rst_ex", 168'(ms_ex), 168'd0);
        chk("rst_fwd0", 168'(ms_forward[0]), 168'd0);
        chk("rst_allowin", 168'(ms_allowin), 168'd1);

        // 1: ld.b addr 3, data_ok two cycles after entry
        b1 = mk_bus(32'h1c000000, 5'd5, 32'h10000003, 1'b0, 16'h0, 1'b1, 1'b1, 3'b001, 1'b0);
        es_to_ms_valid = 1'b1; es_to_ms_bus = b1;
        cyc();
        es_to_ms_valid = 1'b0;
        settle();
        chk("t1_wait_vld", 168'(ms_to_ws_valid), 168'd0);
        chk("t1_block0", 168'(ms_forward[39]), 168'd1);
        chk("t1_allowin", 168'(ms_allowin), 168'd0);
        cyc();
        chk("t1_block1", 168'(ms_forward[39]), 168'd1);
        cyc();
        data_sram_data_ok = 1'b1; data_sram_rdata = 32'h80123456;
        settle();
        chk("t1_valid", 168'(ms_to_ws_valid), 168'd1);
        chk("t1_bus", ms_to_ws_bus, exp_out(b1, 32'hFFFFFF80));
        chk("t1_block_off", 168'(ms_forward[39]), 168'd0);
        chk("t1_fwd", 168'(ms_forward[38:0]), 168'({32'hFFFFFF80, 5'd5, 1'b1, 1'b1}));
        cyc();
        data_sram_data_ok = 1'b0;
        settle();
        chk("t1_gone", 168'(ms_to_ws_valid), 168'd0);

        // 2: ld.hu addr 2, response buffered while WB stalls for 3 cycles
        b2 = mk_bus(32'h1c000004, 5'd6, 32'h00002002, 1'b0, 16'h0, 1'b1, 1'b1, 3'b100, 1'b0);
        es_to_ms_valid = 1'b1; es_to_ms_bus = b2;
        cyc();
        es_to_ms_valid = 1'b0;
        ws_allowin = 1'b0; data_sram_data_ok = 1'b1; data_sram_rdata = 32'hBEEF1234;
        settle();
        chk("t2_vld0", 168'(ms_to_ws_valid), 168'd1);
        chk("t2_res0", 168'(ms_to_ws_bus[71:40]), 168'(32'h0000BEEF));
        chk("t2_allow0", 168'(ms_allowin), 168'd0);
        cyc();
        data_sram_data_ok = 1'b0; data_sram_rdata = 32'hDEADDEAD;
        settle();
        chk("t2_buf_res1", 168'(ms_to_ws_bus[71:40]), 168'(32'h0000BEEF));
        chk("t2_allow1", 168'(ms_allowin), 168'd0);
        cyc();
        chk("t2_buf_vld2", 168'(ms_to_ws_valid), 168'd1);
        chk("t2_buf_res2", 168'(ms_to_ws_bus[71:40]), 168'(32'h0000BEEF));
        cyc();
        ws_allowin = 1'b1;
        settle();
        chk("t2_xfer", ms_to_ws_bus, exp_out(b2, 32'h0000BEEF));
        chk("t2_allow3", 168'(ms_allowin), 168'd1);
        cyc();
        chk("t2_no_dup", 168'(ms_to_ws_valid), 168'd0);

        // 3: flush with a response still owed; that response must be discarded
        b3a = mk_bus(32'h1c000008, 5'd8, 32'h00003000, 1'b0, 16'h0, 1'b1, 1'b1, 3'b000, 1'b0);
        b3b = mk_bus(32'h1c00000c, 5'd7, 32'h00004000, 1'b0, 16'h0, 1'b1, 1'b1, 3'b000, 1'b0);
        es_to_ms_valid = 1'b1; es_to_ms_bus = b3a;
        cyc();
        es_to_ms_valid = 1'b0; flush = 1'b1;
        settle();
        chk("t3_flush_vld", 168'(ms_to_ws_valid), 168'd0);
        cyc();
        flush = 1'b0;
        es_to_ms_valid = 1'b1; es_to_ms_bus = b3b;
        settle();
        chk("t3_allowin", 168'(ms_allowin), 168'd1);
        cyc();
        es_to_ms_valid = 1'b0;
        data_sram_data_ok = 1'b1; data_sram_rdata = 32'h11111111;
        settle();
        chk("t3_drop_vld", 168'(ms_to_ws_valid), 168'd0);
        chk("t3_drop_blk", 168'(ms_forward[39]), 168'd1);
        cyc();
        data_sram_rdata = 32'h22222222;
        settle();
        chk("t3_vld", 168'(ms_to_ws_valid), 168'd1);
        chk("t3_bus", ms_to_ws_bus, exp_out(b3b, 32'h22222222));
        cyc();
        data_sram_data_ok = 1'b0;
        settle();
        chk("t3_gone", 168'(ms_to_ws_valid), 168'd0);

        // 4: excepting memory op goes straight to WB without any response
        b4 = mk_bus(32'h1c000010, 5'd9, 32'h00005001, 1'b1, 16'h0009, 1'b1, 1'b1, 3'b000, 1'b0);
        es_to_ms_valid = 1'b1; es_to_ms_bus = b4;
        cyc();
        es_to_ms_valid = 1'b0;
        settle();
        chk("t4_vld", 168'(ms_to_ws_valid), 168'd1);
        chk("t4_ex", 168'(ms_ex), 168'd1);
        chk("t4_excp_f", 168'(ms_to_ws_bus[88:72]), 168'({16'h0009, 1'b1}));
        chk("t4_pc", 168'(ms_to_ws_bus[31:0]), 168'(32'h1c000010));
        cyc();
        chk("t4_ex_off", 168'(ms_ex), 168'd0);

        // 5: add then ld.w back to back, response in the load's first cycle
        b5a = mk_bus(32'h1c000014, 5'd3, 32'h12345678, 1'b0, 16'h0, 1'b0, 1'b0, 3'b000, 1'b0);
        b5b = mk_bus(32'h1c000018, 5'd4, 32'h00006000, 1'b0, 16'h0, 1'b1, 1'b1, 3'b000, 1'b0);
        es_to_ms_valid = 1'b1; es_to_ms_bus = b5a;
        cyc();
        es_to_ms_bus = b5b;
        settle();
        chk("t5_add_vld", 168'(ms_to_ws_valid), 168'd1);
        chk("t5_add_bus", ms_to_ws_bus, exp_out(b5a, 32'h12345678));
        chk("t5_add_fwd", 168'(ms_forward), 168'({1'b0, 32'h12345678, 5'd3, 1'b1, 1'b1}));
        chk("t5_allowin", 168'(ms_allowin), 168'd1);
        cyc();
        es_to_ms_valid = 1'b0;
        data_sram_data_ok = 1'b1; data_sram_rdata = 32'hCAFEF00D;
        settle();
        chk("t5_ld_vld", 168'(ms_to_ws_valid), 168'd1);
        chk("t5_ld_fwd", 168'(ms_forward), 168'({1'b0, 32'hCAFEF00D, 5'd4, 1'b1, 1'b1}));
        cyc();
        data_sram_data_ok = 1'b0;
        settle();
        chk("t5_gone", 168'(ms_to_ws_valid), 168'd0);

        // 6: reset while a load waits with cancel pending
        es_to_ms_valid = 1'b1; es_to_ms_bus = b3a;
        cyc();
        es_to_ms_valid = 1'b0; flush = 1'b1;
        cyc();
        flush = 1'b0;
        es_to_ms_valid = 1'b1; es_to_ms_bus = b3b;
        cyc();
        es_to_ms_valid = 1'b0; reset = 1'b1;
        cyc();
        reset = 1'b0;
        settle();
        chk("t6_vld", 168'(ms_to_ws_valid), 168'd0);
        chk("t6_ex", 168'(ms_ex), 168'd0);
        chk("t6_fwd0", 168'(ms_forward[0]), 168'd0);
        chk("t6_allowin", 168'(ms_allowin), 168'd1);
        b6 = mk_bus(32'h1c00001c, 5'd10, 32'h00007000, 1'b0, 16'h0, 1'b1, 1'b1, 3'b000, 1'b0);
        es_to_ms_valid = 1'b1; es_to_ms_bus = b6;
        cyc();
        es_to_ms_valid = 1'b0;
        data_sram_data_ok = 1'b1; data_sram_rdata = 32'h33333333;
        settle();
        chk("t6_nocancel", 168'(ms_to_ws_valid), 168'd1);
        chk("t6_bus", ms_to_ws_bus, exp_out(b6, 32'h33333333));
        cyc();
        data_sram_data_ok = 1'b0;

        // ertn without memory access raises ms_ex
        es_to_ms_valid = 1'b1;
        es_to_ms_bus = mk_bus(32'h1c000020, 5'd0, 32'd0, 1'b0, 16'h0, 1'b0, 1'b0, 3'b000, 1'b1);
        cyc();
        es_to_ms_valid = 1'b0;
        settle();
        chk("ertn_ex", 168'(ms_ex), 168'd1);
        cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
